screen_sequencer: RTL and testbench
===================================

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter LIVES, default 3, meaning starting lives per player (range 1..3).
REQ-002 SHALL have parameter WIN_HOLD, default 120, meaning frames the win/draw screen is held before the prompt (range 1..255).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-006 SHALL have port start  input  1  level; start request from the title screen.
REQ-007 SHALL have ports yes, no  input  1 each  levels; replay / quit answers at the prompt.
REQ-008 SHALL have ports hit1, hit2  input  1 each  one-cycle pulses; player 1 / player 2 tank destroyed.
REQ-009 SHALL have port screen_sel  output  3  displayed screen: 0 title, 1 game, 2 win1, 3 win2, 4 draw, 5 prompt.
REQ-010 SHALL have port player_screen  output  2  winner code: 00 none, 01 player 1, 10 player 2, 11 draw.
REQ-011 SHALL have port reset_plyrScrn  output  1  high holds the game engine in reset.
REQ-012 SHALL have ports lives1, lives2  output  2 each  remaining lives.

Function
REQ-013 SHALL implement the states TITLE, PLAY, WIN1, WIN2, DRAW, PROMPT; screen_sel SHALL equal the state encoding of REQ-009.
REQ-014 SHALL compute the next state on every cycle but SHALL commit a state change only in a cycle where frame_tick=1; requests pending between ticks SHALL be held (sticky) until the next tick.
REQ-015 SHALL register start, yes and no and act only on their rising edge; levels held across a state change SHALL NOT retrigger.
REQ-016 TITLE: a start rising edge SHALL request PLAY; lives1 and lives2 SHALL load LIVES on the committing tick.
REQ-017 PLAY: each hit1 pulse SHALL decrement lives1 by 1 in the same cycle, and each hit2 pulse SHALL decrement lives2; a counter already at 0 SHALL saturate at 0.
REQ-018 PLAY: lives1=0 with lives2>0 SHALL request WIN2; lives2=0 with lives1>0 SHALL request WIN1; both 0 SHALL request DRAW, including simultaneous final hits.
REQ-019 Hits SHALL be ignored outside PLAY and after a win/draw request is pending.
REQ-020 WIN1/WIN2/DRAW SHALL count frame_tick pulses with an 8-bit counter cleared on entry, and SHALL request PROMPT when the count reaches WIN_HOLD.
REQ-021 PROMPT: a yes edge SHALL request PLAY with lives reloaded; a no edge SHALL request TITLE; if both edges occur in the same cycle, no SHALL win.
REQ-022 player_screen SHALL be 01 in WIN1, 10 in WIN2, 11 in DRAW, hold its value through PROMPT, and be 00 in TITLE and PLAY.
REQ-023 reset_plyrScrn SHALL be 0 only in PLAY; it SHALL rise in the same cycle PLAY is exited and fall in the cycle PLAY is entered.
REQ-024 All outputs SHALL be registered, with zero combinational path from inputs to outputs.

Reset
REQ-025 reset=0 SHALL immediately force: state TITLE, screen_sel=0, player_screen=00, reset_plyrScrn=1, lives1=lives2=0, hold counter 0, pending requests and edge registers cleared.
REQ-026 Reset asserted mid-game or mid-hold SHALL abandon the operation; after release the block SHALL wait for a fresh start edge.
REQ-027 A start level held high through reset release SHALL NOT start a game.

Verification
REQ-028 Reset release, start pulse, then frame_tick -> screen_sel=1, lives1=lives2=3, reset_plyrScrn=0 on that tick, not before.
REQ-029 PLAY, three hit2 pulses, then tick -> lives2=0, screen_sel=2, player_screen=01; after 120 further ticks -> screen_sel=5.
REQ-030 PLAY with lives1=lives2=1, hit1 and hit2 in the same cycle, then tick -> screen_sel=4, player_screen=11.
REQ-031 PROMPT, yes and no rising in the same cycle, then tick -> screen_sel=0, player_screen=00.
REQ-032 PROMPT, yes edge -> screen_sel stays 5 until the next tick, then becomes 1 with lives reloaded to 3 and player_screen=00.
REQ-033 Reset pulled low during WIN1 hold at count 50 -> outputs at reset values instantly; start held high across release -> no transition to PLAY.

Source files
------------

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - screen/game-flow sequencer for a two-player tank game.
module screen_sequencer #(
  parameter int LIVES    = 3,
  parameter int WIN_HOLD = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       yes,
  input  logic       no,
  input  logic       hit1,
  input  logic       hit2,
  output logic [2:0] screen_sel,
  output logic [1:0] player_screen,
  output logic       reset_plyrScrn,
  output logic [1:0] lives1,
  output logic [1:0] lives2
);

  typedef enum logic [2:0] {
    S_TITLE  = 3'd0,
    S_PLAY   = 3'd1,
    S_WIN1   = 3'd2,
    S_WIN2   = 3'd3,
    S_DRAW   = 3'd4,
    S_PROMPT = 3'd5
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] HOLD_LAST  = 8'(WIN_HOLD - 1);

  state_t     state_q, state_d;
  state_t     pend_st_q, pend_st_d;
  logic       pend_vld_q, pend_vld_d;
  logic       start_q, start_d, yes_q, yes_d, no_q, no_d;
  logic       armed_q, armed_d;
  logic [1:0] lives1_q, lives1_d, lives2_q, lives2_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] pscr_q, pscr_d;
  logic       rst_ps_q, rst_ps_d;

  state_t     req_st;
  logic       req_vld;
  logic [1:0] l1, l2;
  logic       start_edge, yes_edge, no_edge;

  // armed_q masks the first cycle after reset so a level held through release is not an edge
  assign start_edge = armed_q & start & ~start_q;
  assign yes_edge   = armed_q & yes & ~yes_q;
  assign no_edge    = armed_q & no & ~no_q;

  always_comb begin
    state_d    = state_q;
    pend_st_d  = pend_st_q;
    pend_vld_d = pend_vld_q;
    start_d    = start;
    yes_d      = yes;
    no_d       = no;
    armed_d    = 1'b1;
    lives1_d   = lives1_q;
    lives2_d   = lives2_q;
    hold_d     = hold_q;
    pscr_d     = pscr_q;
    rst_ps_d   = rst_ps_q;
    req_vld    = 1'b0;
    req_st     = state_q;
    l1         = lives1_q;
    l2         = lives2_q;

    case (state_q)
      S_TITLE: begin
        if (start_edge) begin
          req_vld = 1'b1;
          req_st  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (!pend_vld_q) begin
          if (hit1 && lives1_q != 2'd0) l1 = lives1_q - 2'd1;
          if (hit2 && lives2_q != 2'd0) l2 = lives2_q - 2'd1;
          lives1_d = l1;
          lives2_d = l2;
          if (l1 == 2'd0 && l2 == 2'd0) begin
            req_vld = 1'b1;
            req_st  = S_DRAW;
          end else if (l1 == 2'd0) begin
            req_vld = 1'b1;
            req_st  = S_WIN2;
          end else if (l2 == 2'd0) begin
            req_vld = 1'b1;
            req_st  = S_WIN1;
          end
        end
      end
      S_WIN1, S_WIN2, S_DRAW: begin
        if (frame_tick) hold_d = hold_q + 8'd1;
        if (hold_q == HOLD_LAST) begin
          req_vld = 1'b1;
          req_st  = S_PROMPT;
        end
      end
      S_PROMPT: begin
        if (no_edge) begin
          req_vld = 1'b1;
          req_st  = S_TITLE;
        end else if (yes_edge) begin
          req_vld = 1'b1;
          req_st  = S_PLAY;
        end
      end
      default: begin
        req_vld = 1'b1;
        req_st  = S_TITLE;
      end
    endcase

    if (req_vld) begin
      pend_vld_d = 1'b1;
      pend_st_d  = req_st;
    end

    // state and every screen-facing output change together on the committing tick
    if (frame_tick && pend_vld_d) begin
      state_d    = pend_st_d;
      pend_vld_d = 1'b0;
      hold_d     = 8'd0;
      rst_ps_d   = 1'b1;
      case (pend_st_d)
        S_PLAY: begin
          lives1_d = LIVES_INIT;
          lives2_d = LIVES_INIT;
          pscr_d   = 2'b00;
          rst_ps_d = 1'b0;
        end
        S_WIN1:   pscr_d = 2'b01;
        S_WIN2:   pscr_d = 2'b10;
        S_DRAW:   pscr_d = 2'b11;
        S_PROMPT: pscr_d = pscr_q;
        default:  pscr_d = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_TITLE;
      pend_st_q  <= S_TITLE;
      pend_vld_q <= 1'b0;
      start_q    <= 1'b0;
      yes_q      <= 1'b0;
      no_q       <= 1'b0;
      armed_q    <= 1'b0;
      lives1_q   <= 2'd0;
      lives2_q   <= 2'd0;
      hold_q     <= 8'd0;
      pscr_q     <= 2'b00;
      rst_ps_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      pend_st_q  <= pend_st_d;
      pend_vld_q <= pend_vld_d;
      start_q    <= start_d;
      yes_q      <= yes_d;
      no_q       <= no_d;
      armed_q    <= armed_d;
      lives1_q   <= lives1_d;
      lives2_q   <= lives2_d;
      hold_q     <= hold_d;
      pscr_q     <= pscr_d;
      rst_ps_q   <= rst_ps_d;
    end
  end

  assign screen_sel     = state_q;
  assign player_screen  = pscr_q;
  assign reset_plyrScrn = rst_ps_q;
  assign lives1         = lives1_q;
  assign lives2         = lives2_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - directed scoreboard bench for screen_sequencer.
module tb_screen_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       yes = 1'b0;
  logic       no = 1'b0;
  logic       hit1 = 1'b0;
  logic       hit2 = 1'b0;
  logic [2:0] screen_sel;
  logic [1:0] player_screen;
  logic       reset_plyrScrn;
  logic [1:0] lives1;
  logic [1:0] lives2;

  typedef struct packed {
    logic [2:0] sel;
    logic [1:0] ps;
    logic       rp;
    logic [1:0] l1;
    logic [1:0] l2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  screen_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .yes(yes), .no(no), .hit1(hit1), .hit2(hit2),
    .screen_sel(screen_sel), .player_screen(player_screen),
    .reset_plyrScrn(reset_plyrScrn), .lives1(lives1), .lives2(lives2)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hit(input logic a, input logic b);
    hit1 = a;
    hit2 = b;
    cyc();
    hit1 = 1'b0;
    hit2 = 1'b0;
    cyc();
  endtask

  task automatic press_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  task automatic expect_out(input logic [2:0] sel, input logic [1:0] ps, input logic rp,
                            input logic [1:0] l1, input logic [1:0] l2);
    exp_t e;
    e.sel = sel; e.ps = ps; e.rp = rp; e.l1 = l1; e.l2 = l2;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp_v);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    n_cmp++;
    assert (sb.size() > 0)
    else begin
      n_bad++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(tag, "screen_sel", int'(screen_sel), int'(e.sel));
      cmp(tag, "player_screen", int'(player_screen), int'(e.ps));
      cmp(tag, "reset_plyrScrn", int'(reset_plyrScrn), int'(e.rp));
      cmp(tag, "lives1", int'(lives1), int'(e.l1));
      cmp(tag, "lives2", int'(lives2), int'(e.l2));
    end
  endtask

  initial begin
    cyc(); cyc();
    expect_out(3'd0, 2'b00, 1'b1, 2'd0, 2'd0);
    check("reset");

    reset = 1'b1;
    cyc(); cyc();
    press_start();
    expect_out(3'd0, 2'b00, 1'b1, 2'd0, 2'd0);
    check("start_before_tick");
    tick();
    expect_out(3'd1, 2'b00, 1'b0, 2'd3, 2'd3);
    check("start_tick_play");

    hit(1'b1, 1'b0);
    expect_out(3'd1, 2'b00, 1'b0, 2'd2, 2'd3);
    check("hit1_dec");
    hit(1'b0, 1'b1); hit(1'b0, 1'b1); hit(1'b0, 1'b1);
    hit(1'b1, 1'b0);
    expect_out(3'd1, 2'b00, 1'b0, 2'd2, 2'd0);
    check("win1_pending_hits_ignored");
    tick();
    expect_out(3'd2, 2'b01, 1'b1, 2'd2, 2'd0);
    check("win1_enter");
    ticks(119);
    expect_out(3'd2, 2'b01, 1'b1, 2'd2, 2'd0);
    check("win1_hold_119");
    tick();
    expect_out(3'd5, 2'b01, 1'b1, 2'd2, 2'd0);
    check("win1_prompt_120");

    yes = 1'b1; cyc(); cyc(); cyc();
    expect_out(3'd5, 2'b01, 1'b1, 2'd2, 2'd0);
    check("yes_sticky_wait");
    tick();
    yes = 1'b0;
    expect_out(3'd1, 2'b00, 1'b0, 2'd3, 2'd3);
    check("yes_replay");
    cyc(); cyc();

    hit(1'b1, 1'b0); hit(1'b1, 1'b0);
    hit(1'b0, 1'b1); hit(1'b0, 1'b1);
    expect_out(3'd1, 2'b00, 1'b0, 2'd1, 2'd1);
    check("both_one_life");
    hit(1'b1, 1'b1);
    tick();
    expect_out(3'd4, 2'b11, 1'b1, 2'd0, 2'd0);
    check("draw_simultaneous");
    ticks(120);
    expect_out(3'd5, 2'b11, 1'b1, 2'd0, 2'd0);
    check("draw_prompt");

    yes = 1'b1; no = 1'b1; cyc();
    yes = 1'b0; no = 1'b0; cyc();
    tick();
    expect_out(3'd0, 2'b00, 1'b1, 2'd0, 2'd0);
    check("yes_no_tie_title");

    press_start(); tick();
    hit(1'b1, 1'b0); hit(1'b1, 1'b0); hit(1'b1, 1'b0);
    tick();
    expect_out(3'd3, 2'b10, 1'b1, 2'd0, 2'd3);
    check("win2_enter");
    hit(1'b0, 1'b1);
    ticks(120);
    expect_out(3'd5, 2'b10, 1'b1, 2'd0, 2'd3);
    check("win2_prompt_hits_ignored");
    no = 1'b1; cyc(); no = 1'b0; cyc(); cyc();
    tick();
    expect_out(3'd0, 2'b00, 1'b1, 2'd0, 2'd3);
    check("no_title");

    press_start(); tick();
    hit(1'b0, 1'b1); hit(1'b0, 1'b1); hit(1'b0, 1'b1);
    tick();
    ticks(50);
    expect_out(3'd2, 2'b01, 1'b1, 2'd3, 2'd0);
    check("win1_hold_50");
    start = 1'b1;
    #2 reset = 1'b0;
    #1;
    expect_out(3'd0, 2'b00, 1'b1, 2'd0, 2'd0);
    check("async_reset_mid_hold");
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    ticks(3);
    expect_out(3'd0, 2'b00, 1'b1, 2'd0, 2'd0);
    check("start_held_through_release");
    start = 1'b0; cyc();
    press_start(); tick();
    expect_out(3'd1, 2'b00, 1'b0, 2'd3, 2'd3);
    check("fresh_start_after_reset");

    n_cmp++;
    assert (sb.size() == 0)
    else begin
      n_bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
